alu_mdstep_seq: RTL and testbench
=================================

# alu_mdstep_seq

Iterative unsigned multiply/divide sequencer for the CADR-style ALU datapath. It holds the accumulator (A) and Q register and steps them once per clock through a WIDTH-bit adder. The adder is built from 4-bit ALU slices whose active-low propagate/generate outputs feed a two-level carry-lookahead, so the block is the slice stage directly upstream of the lookahead generator. A start/busy/done handshake connects it to microcode control.

## Interface
- `WIDTH`, default 32. Datapath width. Must be 16 or 32 (a multiple of 4).
- `clk`  in  1  Single clock, rising edge.
- `reset`  in  1  Synchronous, active-high.
- `start`  in  1  Request. Sampled only in IDLE or DONE.
- `op`  in  1  0 = multiply, 1 = divide.
- `a_in`  in  WIDTH  Multiplier / dividend.
- `b_in`  in  WIDTH  Multiplicand / divisor.
- `busy`  out  1  High while state is RUN.
- `done`  out  1  One-cycle pulse; results valid.
- `err`  out  1  Divide by zero, or divide with the feature compiled out. Held until the next accepted start.
- `result_hi`  out  WIDTH  Accumulator: product high word / remainder.
- `result_lo`  out  WIDTH  Q: product low word / quotient.

## Operation
- **Registers:** A, Q, M (operand latch), step counter of clog2(WIDTH) bits, state.
- **States and transitions:**
  - IDLE → RUN on `start`.
  - RUN → DONE after the WIDTH-th step.
  - DONE → IDLE when `start`=0.
  - DONE → RUN when `start`=1 (back-to-back).
- **Accepted start:**
  - M ← b_in, Q ← a_in, A ← 0, count ← 0, err ← 0, op latched.
  - Inputs are not used after the accepting edge.
  - `start` while in RUN is ignored.
- **Multiply step:**
  - sum = A + (Q[0] ? M : 0), giving carry c.
  - {A,Q} ← {c, sum, Q[WIDTH-1:1]}.
- **Divide step (restoring):**
  - {A',Q'} = {A,Q} << 1.
  - trial = A' − M, computed as A' + ~M with carry-in 1.
  - Carry-out 1 (no borrow): A ← trial, Q ← Q' | 1.
  - Carry-out 0: A ← A', Q ← Q'.
  - Carry out of the shifted A' MSB also forces acceptance, so 33-bit magnitude is handled.
- **Divide by zero:** b_in = 0 with op = 1 at the accepting edge goes straight to DONE on the next edge with err=1, result_lo = all ones, result_hi = a_in.
- **Adder:**
  - WIDTH/4 slices, each computing sum, P_n, G_n.
  - Per-group carries come from lookahead on the slice P_n/G_n with active-low carry-in. No ripple between slices.
- **Outputs:** result_hi/result_lo are A/Q directly. They are stable from DONE until the next accepted start.

## Timing
- **Reset values:** state IDLE; A, Q, M, count = 0; busy=0, done=0, err=0, result_hi=0, result_lo=0.
- **Reset mid-operation:** takes effect at that edge and overrides start. No done is produced for the aborted operation.
- **Latency:**
  - Start sampled at edge 0; steps occur at edges 1..WIDTH.
  - done is high during the cycle after edge WIDTH, i.e. WIDTH+1 cycles after start was presented.
  - Divide-by-zero: done during the cycle after edge 1.
- **busy:** high from the cycle after edge 0 through the cycle after edge WIDTH−1.
- **done and busy:** never high together.
- **Throughput:** back-to-back operation gives one result every WIDTH+1 cycles.
- **Counter:** wraps to 0 on RUN→DONE.

## Configuration
- **`ALU_MDSTEP_DIV_EN` defined:** divide path, trial-subtract mux and divide-by-zero detect are built.
- **`ALU_MDSTEP_DIV_EN` undefined:**
  - Only multiply is built.
  - An accepted start with op=1 goes to DONE after one edge with err=1, result_hi = 0, result_lo = 0.
  - Multiply timing is unchanged.

## Structure
- **Shared package `alu_pkg`:** state enum (IDLE, RUN, DONE), op encodings (OP_MUL, OP_DIV), slice function-select constants (ADD, SUB).
- **Sub-module `alu_slice4`:** 4-bit arithmetic slice.
  - Inputs: a[3:0], b[3:0], function select, cin_n.
  - Outputs: f[3:0], p_n, g_n.
  - Instantiated WIDTH/4 times.
- **Top level:** lookahead equations, sequencer and registers.

## Test plan
- **Multiply small:** start, op=0, a_in=7, b_in=6 → done in cycle 33; result_hi=0, result_lo=42; err=0.
- **Multiply max:** a_in=b_in=0xFFFFFFFF → result_hi=0xFFFFFFFE, result_lo=0x00000001. This exercises the full carry-lookahead path.
- **Divide:** a_in=100, b_in=7 → result_lo=14, result_hi=2. Also a_in=0xFFFFFFFF, b_in=0x80000000 → result_lo=1, result_hi=0x7FFFFFFF.
- **Divide by zero:** a_in=0x1234, b_in=0 → done in cycle 2, err=1, result_lo=0xFFFFFFFF, result_hi=0x1234.
- **Reset during RUN:** assert reset at step 10 → next cycle busy=0, outputs 0, no done. A following 3×5 multiply gives 15.
- **Handshake:**
  - start pulsed while busy is ignored; the original result is unchanged.
  - start held through DONE → new operation begins immediately; second done exactly 33 cycles after the first.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the multiply/divide step sequencer.
// Holds the sequencer state encoding, the op encodings and the 4-bit
// slice function-select values. The carry-lookahead group helper is
// shared by the slice and the top-level lookahead.
package alu_pkg;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Operation select as presented on the op input
    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;

    // Slice function select: ADD passes b, SUB inverts b (carry-in supplies the +1)
    localparam logic FN_ADD = 1'b0;
    localparam logic FN_SUB = 1'b1;

    // Group generate/propagate over four active-high g/p pairs.
    // Returns {group_generate, group_propagate}.
    function automatic logic [1:0] claGroup(input logic [3:0] g, input logic [3:0] p);
        logic grpG;
        logic grpP;
        grpG = g[3]
             | (p[3] & g[2])
             | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0]);
        grpP = &p;
        return {grpG, grpP};
    endfunction

endpackage

// File: rtl/alu_slice4.sv
// alu_slice4: 4-bit arithmetic slice.
// Produces the 4-bit sum plus active-low group propagate/generate so the
// slice can sit directly in front of an external lookahead generator.
// The carry-in is active-low, matching the lookahead generator outputs.
module alu_slice4
    import alu_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       fsel,
    input  logic       cin_n,
    output logic [3:0] f,
    output logic       p_n,
    output logic       g_n
);

    logic [3:0] bSel;
    logic [3:0] bitP;
    logic [3:0] bitG;
    logic [3:0] bitC;
    logic [1:0] grp;

    // Operand conditioning, in-slice lookahead carries, sum and group P/G
    always_comb begin
        bSel = (fsel == FN_SUB) ? ~b : b;
        bitP = a | bSel;
        bitG = a & bSel;
        bitC[0] = ~cin_n;
        bitC[1] = bitG[0] | (bitP[0] & bitC[0]);
        bitC[2] = bitG[1] | (bitP[1] & bitG[0]) | (bitP[1] & bitP[0] & bitC[0]);
        bitC[3] = bitG[2] | (bitP[2] & bitG[1]) | (bitP[2] & bitP[1] & bitG[0])
                | (bitP[2] & bitP[1] & bitP[0] & bitC[0]);
        f   = a ^ bSel ^ bitC;
        grp = claGroup(bitG, bitP);
        g_n = ~grp[1];
        p_n = ~grp[0];
    end

endmodule

// File: rtl/alu_mdstep_seq.sv
// alu_mdstep_seq: iterative unsigned multiply / restoring divide sequencer.
// A (accumulator) and Q are stepped once per clock through a WIDTH-bit adder
// built from alu_slice4 slices and a two-level carry-lookahead.
// WIDTH must be 16 or 32.
// Build option: define ALU_MDSTEP_DIV_EN to build the divide path, the
// trial-subtract mux and divide-by-zero detection. Without it only multiply
// is built and a divide request finishes after one step with err set.
module alu_mdstep_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] result_hi,
    output logic [WIDTH-1:0] result_lo
);

    localparam int NS = WIDTH / 4;
    localparam int NB = NS / 4;
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    state_t           state_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] m_q;
    logic [CW-1:0]    cnt_q;
    logic             op_q;
    logic             busy_q;
    logic             done_q;
    logic             err_q;

    logic [WIDTH-1:0] addX;
    logic [WIDTH-1:0] addY;
    logic [WIDTH-1:0] addSum;
    logic             addFn;
    logic             addCin;
    logic             addCout;

    logic [NS-1:0]    sliceP_n;
    logic [NS-1:0]    sliceG_n;
    logic [NS-1:0]    sliceProp;
    logic [NS-1:0]    sliceGen;
    logic [NS-1:0]    sliceC;
    logic [NS-1:0]    sliceCin_n;
    logic [NB-1:0]    blockG;
    logic [NB-1:0]    blockP;
    logic [NB:0]      blockC;

    logic [WIDTH-1:0] stepAcc_d;
    logic [WIDTH-1:0] stepQ_d;
`ifdef ALU_MDSTEP_DIV_EN
    logic [WIDTH-1:0] accShift;
`endif

    for (genvar gi = 0; gi < NS; gi++) begin : gSlice
        alu_slice4 uSlice (
            .a     (addX[4*gi +: 4]),
            .b     (addY[4*gi +: 4]),
            .fsel  (addFn),
            .cin_n (sliceCin_n[gi]),
            .f     (addSum[4*gi +: 4]),
            .p_n   (sliceP_n[gi]),
            .g_n   (sliceG_n[gi])
        );
    end

    assign sliceCin_n = ~sliceC;
    assign addCout    = blockC[NB];

    // Two-level lookahead: slice P/G form block P/G, block carries come from
    // a flat lookahead over blocks, and slice carries from a flat lookahead
    // inside each block, so no carry ripples from one slice to the next
    always_comb begin : pLookahead
        logic laAcc;
        logic laTerm;
        laAcc     = 1'b0;
        laTerm    = 1'b0;
        sliceProp = ~sliceP_n;
        sliceGen  = ~sliceG_n;
        blockG    = '0;
        blockP    = '0;
        blockC    = '0;
        sliceC    = '0;
        for (int b = 0; b < NB; b++) begin
            {blockG[b], blockP[b]} = claGroup(sliceGen[4*b +: 4], sliceProp[4*b +: 4]);
        end
        for (int b = 0; b <= NB; b++) begin
            laAcc = addCin;
            for (int m = 0; m < b; m++) begin
                laAcc = laAcc & blockP[m];
            end
            for (int k = 0; k < b; k++) begin
                laTerm = blockG[k];
                for (int m = k + 1; m < b; m++) begin
                    laTerm = laTerm & blockP[m];
                end
                laAcc = laAcc | laTerm;
            end
            blockC[b] = laAcc;
        end
        for (int s = 0; s < NS; s++) begin
            laAcc = blockC[s / 4];
            for (int m = 4 * (s / 4); m < s; m++) begin
                laAcc = laAcc & sliceProp[m];
            end
            for (int k = 4 * (s / 4); k < s; k++) begin
                laTerm = sliceGen[k];
                for (int m = k + 1; m < s; m++) begin
                    laTerm = laTerm & sliceProp[m];
                end
                laAcc = laAcc | laTerm;
            end
            sliceC[s] = laAcc;
        end
    end

    // One multiply or divide step: choose adder operands and form next A/Q
    always_comb begin
        addX      = acc_q;
        addY      = '0;
        addFn     = FN_ADD;
        addCin    = 1'b0;
        stepAcc_d = acc_q;
        stepQ_d   = q_q;
`ifdef ALU_MDSTEP_DIV_EN
        accShift  = {acc_q[WIDTH-2:0], q_q[WIDTH-1]};
`endif
        if (op_q == OP_MUL) begin
            addY      = q_q[0] ? m_q : '0;
            stepAcc_d = {addCout, addSum[WIDTH-1:1]};
            stepQ_d   = {addSum[0], q_q[WIDTH-1:1]};
        end
`ifdef ALU_MDSTEP_DIV_EN
        else begin
            // The bit shifted out of A is the 33rd magnitude bit; when set,
            // the shifted value is certainly >= M so the trial is accepted
            addX   = accShift;
            addY   = m_q;
            addFn  = FN_SUB;
            addCin = 1'b1;
            if (addCout || acc_q[WIDTH-1]) begin
                stepAcc_d = addSum;
                stepQ_d   = {q_q[WIDTH-2:0], 1'b1};
            end else begin
                stepAcc_d = accShift;
                stepQ_d   = {q_q[WIDTH-2:0], 1'b0};
            end
        end
`endif
    end

    // Sequencer: handshake, operand latch, step counter and registered flags
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            q_q     <= '0;
            m_q     <= '0;
            cnt_q   <= '0;
            op_q    <= OP_MUL;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        m_q     <= b_in;
                        q_q     <= a_in;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        err_q   <= 1'b0;
                        op_q    <= op;
                        busy_q  <= 1'b1;
                        state_q <= ST_RUN;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_RUN: begin
`ifdef ALU_MDSTEP_DIV_EN
                    if (op_q == OP_DIV && m_q == '0) begin
                        acc_q   <= q_q;
                        q_q     <= '1;
                        err_q   <= 1'b1;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end
`else
                    if (op_q == OP_DIV) begin
                        acc_q   <= '0;
                        q_q     <= '0;
                        err_q   <= 1'b1;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end
`endif
                    else begin
                        acc_q <= stepAcc_d;
                        q_q   <= stepQ_d;
                        cnt_q <= cnt_q + CW'(1);
                        if (cnt_q == LAST_STEP) begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= ST_DONE;
                        end
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign result_hi = acc_q;
    assign result_lo = q_q;

endmodule

// File: tb/tb_alu_mdstep_seq.sv
// tb_alu_mdstep_seq: self-checking bench for alu_mdstep_seq (WIDTH = 32).
// Expected results come from a plain-arithmetic model of multiply/divide.
// Divide expectations follow ALU_MDSTEP_DIV_EN, which must be defined the
// same way for bench and design.
module tb_alu_mdstep_seq;

    localparam int W = 32;

    logic         clk   = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic         op    = 1'b0;
    logic [W-1:0] aIn   = '0;
    logic [W-1:0] bIn   = '0;
    logic         busy;
    logic         done;
    logic         err;
    logic [W-1:0] resultHi;
    logic [W-1:0] resultLo;

    int testsRun    = 0;
    int testsFailed = 0;

    // Free-running clock, 10 time-unit period
    always #5 clk = ~clk;

    alu_mdstep_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .a_in      (aIn),
        .b_in      (bIn),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .result_hi (resultHi),
        .result_lo (resultLo)
    );

    // Hard stop in case something stalls outside the bounded waits
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time exceeded, got timeout expected finish");
        $fatal(1, "[TB] watchdog");
    end

    // Reference model: results, error flag and edges from accept to done
    task automatic modelOp(input logic o, input logic [W-1:0] a, input logic [W-1:0] b,
                           output logic [W-1:0] expHi, output logic [W-1:0] expLo,
                           output logic expErr, output int expLat);
        logic [2*W-1:0] prod;
        prod = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        if (o == 1'b0) begin
            expHi  = prod[2*W-1:W];
            expLo  = prod[W-1:0];
            expErr = 1'b0;
            expLat = W;
        end else begin
`ifdef ALU_MDSTEP_DIV_EN
            if (b == '0) begin
                expHi  = a;
                expLo  = '1;
                expErr = 1'b1;
                expLat = 1;
            end else begin
                expHi  = a % b;
                expLo  = a / b;
                expErr = 1'b0;
                expLat = W;
            end
`else
            expHi  = '0;
            expLo  = '0;
            expErr = 1'b1;
            expLat = 1;
`endif
        end
    endtask

    // Issue one operation and wait (bounded) for done; reports edges from
    // the accepting edge to done, and any busy/done protocol violations
    task automatic applyStimulus(input logic o, input logic [W-1:0] a, input logic [W-1:0] b,
                                 output int lat, output logic overlap, output logic busyLow);
        start = 1'b1;
        op    = o;
        aIn   = a;
        bIn   = b;
        @(posedge clk);
        #1;
        start   = 1'b0;
        op      = 1'($urandom & 1);
        aIn     = $urandom;
        bIn     = $urandom;
        lat     = -1;
        overlap = 1'b0;
        busyLow = !busy;
        for (int n = 1; n <= 200; n++) begin
            @(posedge clk);
            #1;
            if (busy && done) overlap = 1'b1;
            if (done) begin
                lat = n;
                break;
            end
            if (!busy) busyLow = 1'b1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        testsRun++; if (busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        testsRun++; if (done !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
        testsRun++; if (err !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_err: got %b expected 0", err); end
        testsRun++; if (resultHi !== '0) begin testsFailed++; $display("[TB] FAIL reset_hi: got %h expected 0", resultHi); end
        testsRun++; if (resultLo !== '0) begin testsFailed++; $display("[TB] FAIL reset_lo: got %h expected 0", resultLo); end
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        testsRun++; if ({busy, done} !== 2'b00) begin testsFailed++; $display("[TB] FAIL idle_flags: got %b expected 00", {busy, done}); end
    endtask

    task automatic test_multiply();
        logic [W-1:0] a, b, eh, el;
        logic ee, ov, bl;
        int elat, lat;
        for (int i = 0; i < 12; i++) begin
            case (i)
                0:       begin a = 32'd7;        b = 32'd6;        end
                1:       begin a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; end
                2:       begin a = 32'd0;        b = $urandom;     end
                3:       begin a = 32'd1;        b = 32'hFFFFFFFF; end
                4:       begin a = 32'h80000000; b = 32'h80000001; end
                default: begin a = $urandom;     b = $urandom;     end
            endcase
            modelOp(1'b0, a, b, eh, el, ee, elat);
            applyStimulus(1'b0, a, b, lat, ov, bl);
            testsRun++; if (lat !== elat) begin testsFailed++; $display("[TB] FAIL mul_latency[%0d]: got %0d expected %0d", i, lat, elat); end
            testsRun++; if (resultHi !== eh) begin testsFailed++; $display("[TB] FAIL mul_hi[%0d] %h*%h: got %h expected %h", i, a, b, resultHi, eh); end
            testsRun++; if (resultLo !== el) begin testsFailed++; $display("[TB] FAIL mul_lo[%0d] %h*%h: got %h expected %h", i, a, b, resultLo, el); end
            testsRun++; if (err !== ee) begin testsFailed++; $display("[TB] FAIL mul_err[%0d]: got %b expected %b", i, err, ee); end
            testsRun++; if (ov !== 1'b0) begin testsFailed++; $display("[TB] FAIL mul_busy_done_overlap[%0d]: got %b expected 0", i, ov); end
            testsRun++; if (bl !== 1'b0) begin testsFailed++; $display("[TB] FAIL mul_busy_gap[%0d]: got %b expected 0", i, bl); end
            @(posedge clk);
            #1;
            testsRun++; if (done !== 1'b0) begin testsFailed++; $display("[TB] FAIL mul_done_pulse[%0d]: got %b expected 0", i, done); end
            testsRun++; if ({resultHi, resultLo} !== {eh, el}) begin testsFailed++; $display("[TB] FAIL mul_hold[%0d]: got %h expected %h", i, {resultHi, resultLo}, {eh, el}); end
        end
    endtask

    task automatic test_divide();
        logic [W-1:0] a, b, eh, el;
        logic ee, ov, bl;
        int elat, lat;
        for (int i = 0; i < 13; i++) begin
            case (i)
                0:  begin a = 32'd100;        b = 32'd7;        end
                1:  begin a = 32'hFFFFFFFF;   b = 32'h80000000; end
                2:  begin a = 32'h00001234;   b = 32'd0;        end
                3:  begin a = 32'd5;          b = 32'd9;        end
                4:  begin a = 32'hFFFFFFFF;   b = 32'd1;        end
                5:  begin a = $urandom;       b = 32'd0;        end
                6:  begin a = 32'hFFFFFFFE;   b = 32'hFFFFFFFF; end
                default: begin
                    a = $urandom;
                    b = $urandom >> $urandom_range(0, 31);
                    if (b == '0) b = 32'd3;
                end
            endcase
            modelOp(1'b1, a, b, eh, el, ee, elat);
            applyStimulus(1'b1, a, b, lat, ov, bl);
            testsRun++; if (lat !== elat) begin testsFailed++; $display("[TB] FAIL div_latency[%0d]: got %0d expected %0d", i, lat, elat); end
            testsRun++; if (resultHi !== eh) begin testsFailed++; $display("[TB] FAIL div_hi[%0d] %h/%h: got %h expected %h", i, a, b, resultHi, eh); end
            testsRun++; if (resultLo !== el) begin testsFailed++; $display("[TB] FAIL div_lo[%0d] %h/%h: got %h expected %h", i, a, b, resultLo, el); end
            testsRun++; if (err !== ee) begin testsFailed++; $display("[TB] FAIL div_err[%0d]: got %b expected %b", i, err, ee); end
            testsRun++; if (ov !== 1'b0) begin testsFailed++; $display("[TB] FAIL div_busy_done_overlap[%0d]: got %b expected 0", i, ov); end
            testsRun++; if (bl !== 1'b0) begin testsFailed++; $display("[TB] FAIL div_busy_gap[%0d]: got %b expected 0", i, bl); end
            @(posedge clk);
            #1;
            testsRun++; if (err !== ee) begin testsFailed++; $display("[TB] FAIL div_err_hold[%0d]: got %b expected %b", i, err, ee); end
        end
    endtask

    task automatic test_reset_mid();
        logic ov, bl, sawDone;
        int lat;
        start = 1'b1;
        op    = 1'b0;
        aIn   = $urandom | 32'h1;
        bIn   = $urandom | 32'h1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        start = 1'b1;
        aIn   = $urandom;
        bIn   = $urandom;
        @(posedge clk);
        #1;
        reset = 1'b0;
        start = 1'b0;
        testsRun++; if (busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL rst_mid_busy: got %b expected 0", busy); end
        testsRun++; if (done !== 1'b0) begin testsFailed++; $display("[TB] FAIL rst_mid_done: got %b expected 0", done); end
        testsRun++; if ({resultHi, resultLo} !== '0) begin testsFailed++; $display("[TB] FAIL rst_mid_result: got %h expected 0", {resultHi, resultLo}); end
        sawDone = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done || busy) sawDone = 1'b1;
        end
        testsRun++; if (sawDone !== 1'b0) begin testsFailed++; $display("[TB] FAIL rst_mid_no_done: got %b expected 0", sawDone); end
        applyStimulus(1'b0, 32'd3, 32'd5, lat, ov, bl);
        testsRun++; if (lat !== W) begin testsFailed++; $display("[TB] FAIL rst_mid_latency: got %0d expected %0d", lat, W); end
        testsRun++; if ({resultHi, resultLo} !== 64'd15) begin testsFailed++; $display("[TB] FAIL rst_mid_3x5: got %h expected 15", {resultHi, resultLo}); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_start_ignored();
        logic [W-1:0] a, b, eh, el;
        logic ee;
        int elat, lat;
        a = $urandom;
        b = $urandom;
        modelOp(1'b0, a, b, eh, el, ee, elat);
        start = 1'b1;
        op    = 1'b0;
        aIn   = a;
        bIn   = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        start = 1'b1;
        op    = 1'b1;
        aIn   = $urandom;
        bIn   = 32'd0;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat   = -1;
        for (int n = 7; n <= 200; n++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = n;
                break;
            end
        end
        testsRun++; if (lat !== elat) begin testsFailed++; $display("[TB] FAIL ignore_latency: got %0d expected %0d", lat, elat); end
        testsRun++; if (resultHi !== eh) begin testsFailed++; $display("[TB] FAIL ignore_hi: got %h expected %h", resultHi, eh); end
        testsRun++; if (resultLo !== el) begin testsFailed++; $display("[TB] FAIL ignore_lo: got %h expected %h", resultLo, el); end
        testsRun++; if (err !== 1'b0) begin testsFailed++; $display("[TB] FAIL ignore_err: got %b expected 0", err); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] a1, b1, a2, b2, eh1, el1, eh2, el2;
        logic ee;
        int elat, lat1, gap;
        a1 = $urandom;
        b1 = $urandom;
        a2 = $urandom;
        b2 = $urandom;
        modelOp(1'b0, a1, b1, eh1, el1, ee, elat);
        modelOp(1'b0, a2, b2, eh2, el2, ee, elat);
        start = 1'b1;
        op    = 1'b0;
        aIn   = a1;
        bIn   = b1;
        @(posedge clk);
        #1;
        aIn  = a2;
        bIn  = b2;
        lat1 = -1;
        for (int n = 1; n <= 200; n++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat1 = n;
                break;
            end
        end
        testsRun++; if (lat1 !== W) begin testsFailed++; $display("[TB] FAIL b2b_first_latency: got %0d expected %0d", lat1, W); end
        testsRun++; if ({resultHi, resultLo} !== {eh1, el1}) begin testsFailed++; $display("[TB] FAIL b2b_first_result: got %h expected %h", {resultHi, resultLo}, {eh1, el1}); end
        testsRun++; if (busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL b2b_busy_in_done: got %b expected 0", busy); end
        @(posedge clk);
        #1;
        start = 1'b0;
        aIn   = $urandom;
        bIn   = $urandom;
        testsRun++; if ({busy, done} !== 2'b10) begin testsFailed++; $display("[TB] FAIL b2b_restart: got %b expected 10", {busy, done}); end
        gap = -1;
        for (int k = 2; k <= 200; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                gap = k;
                break;
            end
        end
        testsRun++; if (gap !== W + 1) begin testsFailed++; $display("[TB] FAIL b2b_gap: got %0d expected %0d", gap, W + 1); end
        testsRun++; if ({resultHi, resultLo} !== {eh2, el2}) begin testsFailed++; $display("[TB] FAIL b2b_second_result: got %h expected %h", {resultHi, resultLo}, {eh2, el2}); end
        @(posedge clk);
        #1;
    endtask

    // Run every scenario in order, then report
    initial begin
        test_reset();
        test_multiply();
        test_divide();
        test_reset_mid();
        test_start_ignored();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
